// File: rtl/i2c_bit_ctrl_if.sv
// Command channel between the byte-level I2C controller (master side)
// and the bit-level engine (slave side).
interface i2c_bit_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd;
  logic       wr_bit;
  logic       done;
  logic       rd_bit;
  logic       arb_lost;
  logic       busy;

  modport master (
    output cmd_valid, cmd, wr_bit,
    input  cmd_ready, done, rd_bit, arb_lost, busy
  );

  modport slave (
    input  cmd_valid, cmd, wr_bit,
    output cmd_ready, done, rd_bit, arb_lost, busy
  );
endinterface

// File: rtl/i2c_bit_ctrl.sv
// Bit-level I2C master engine. Executes one START/STOP/WRITE/READ command
// at a time as ten tick-driven phases on open-drain SCL/SDA, with clock
// stretching and arbitration-loss detection.
module i2c_bit_ctrl #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clk_tick,
  output logic          tick_en,
  i2c_bit_ctrl_if.slave cmd_if,
  input  logic          scl_in,
  input  logic          sda_in,
  output logic          scl_oe,
  output logic          sda_oe
);

  localparam logic [1:0] CmdStart = 2'b00;
  localparam logic [1:0] CmdStop  = 2'b01;
  localparam logic [1:0] CmdWrite = 2'b10;
  localparam logic [1:0] CmdRead  = 2'b11;

  typedef enum logic [2:0] {StIdle, StStart, StStop, StWrite, StRead} state_e;

  state_e                 state_q, state_d;
  logic [3:0]             ph_q, ph_d;
  logic                   wr_bit_q, wr_bit_d;
  logic                   scl_oe_q, scl_oe_d;
  logic                   sda_oe_q, sda_oe_d;
  logic                   rd_bit_q, rd_bit_d;
  logic                   done_q, done_d;
  logic                   arb_lost_q, arb_lost_d;
  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_s, sda_s;
  logic                   scl_rel;
  logic                   advance;
  logic                   lost;

  // Input synchronizers; reset to 1 so an idle bus is assumed out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
    end
  end

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

  // State, phase counter, latched write bit and registered line drives.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      ph_q       <= 4'd0;
      wr_bit_q   <= 1'b0;
      scl_oe_q   <= 1'b0;
      sda_oe_q   <= 1'b0;
      rd_bit_q   <= 1'b0;
      done_q     <= 1'b0;
      arb_lost_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ph_q       <= ph_d;
      wr_bit_q   <= wr_bit_d;
      scl_oe_q   <= scl_oe_d;
      sda_oe_q   <= sda_oe_d;
      rd_bit_q   <= rd_bit_d;
      done_q     <= done_d;
      arb_lost_q <= arb_lost_d;
    end
  end

  // Next-state: accept, phase advance, sampling, arbitration and line drive.
  always_comb begin
    state_d    = state_q;
    ph_d       = ph_q;
    wr_bit_d   = wr_bit_q;
    scl_oe_d   = scl_oe_q;
    sda_oe_d   = sda_oe_q;
    rd_bit_d   = rd_bit_q;
    done_d     = 1'b0;
    arb_lost_d = 1'b0;
    lost       = 1'b0;
    scl_rel    = 1'b0;

    // Phases in which SCL is released and a slave may stretch it.
    unique case (state_q)
      StStart:         scl_rel = 1'b1;
      StStop:          scl_rel = (ph_q >= 4'd3);
      StWrite, StRead: scl_rel = (ph_q >= 4'd5);
      default:         scl_rel = 1'b0;
    endcase

    advance = clk_tick && (state_q != StIdle) && !(scl_rel && !scl_s);

    if (state_q == StIdle) begin
      if (cmd_if.cmd_valid) begin
        wr_bit_d = cmd_if.wr_bit;
        ph_d     = 4'd0;
        unique case (cmd_if.cmd)
          CmdStart: state_d = StStart;
          CmdStop:  state_d = StStop;
          CmdWrite: state_d = StWrite;
          CmdRead:  state_d = StRead;
          default:  state_d = StIdle;
        endcase
      end
    end else if (advance) begin
      // SDA checks are taken on ticks so synchronizer lag after a release
      // cannot raise a false arbitration loss.
      if (state_q == StStart && ph_q <= 4'd4 && !sda_s) begin
        lost = 1'b1;
      end
      if (state_q == StStop && ph_q >= 4'd8 && !sda_s) begin
        lost = 1'b1;
      end
      if ((state_q == StWrite || state_q == StRead) && ph_q == 4'd6) begin
        rd_bit_d = sda_s;
        if (state_q == StWrite && wr_bit_q && !sda_s) begin
          lost = 1'b1;
        end
      end

      if (lost) begin
        arb_lost_d = 1'b1;
        state_d    = StIdle;
        ph_d       = 4'd0;
      end else if (ph_q == 4'd9) begin
        done_d  = 1'b1;
        state_d = StIdle;
        ph_d    = 4'd0;
      end else begin
        ph_d = ph_q + 4'd1;
      end
    end

    // Line drive follows the phase being entered; idle holds the last drive.
    if (lost) begin
      scl_oe_d = 1'b0;
      sda_oe_d = 1'b0;
    end else begin
      unique case (state_d)
        StStart: begin
          scl_oe_d = 1'b0;
          sda_oe_d = (ph_d >= 4'd5);
        end
        StStop: begin
          scl_oe_d = (ph_d <= 4'd2);
          sda_oe_d = (ph_d <= 4'd6);
        end
        StWrite: begin
          scl_oe_d = (ph_d <= 4'd4);
          if (ph_d >= 4'd2) begin
            sda_oe_d = ~wr_bit_d;
          end
        end
        StRead: begin
          scl_oe_d = (ph_d <= 4'd4);
          sda_oe_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign scl_oe           = scl_oe_q;
  assign sda_oe           = sda_oe_q;
  assign tick_en          = (state_q != StIdle);
  assign cmd_if.cmd_ready = (state_q == StIdle);
  assign cmd_if.busy      = (state_q != StIdle);
  assign cmd_if.done      = done_q;
  assign cmd_if.arb_lost  = arb_lost_q;
  assign cmd_if.rd_bit    = rd_bit_q;

endmodule

// File: tb/tb_i2c_bit_ctrl.sv
// Self-checking bench for i2c_bit_ctrl: directed and randomized command
// sequences checked phase by phase against a behavioural bus model.
module tb_i2c_bit_ctrl;

  localparam logic [1:0] CmdStart = 2'b00;
  localparam logic [1:0] CmdStop  = 2'b01;
  localparam logic [1:0] CmdWrite = 2'b10;
  localparam logic [1:0] CmdRead  = 2'b11;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic clk_tick = 1'b0;
  logic tick_en;
  logic scl_in, sda_in, scl_oe, sda_oe;
  logic ext_scl = 1'b1;
  logic ext_sda = 1'b1;

  // Expected held line drives (1 = pulled low).
  logic exp_scl = 1'b0;
  logic exp_sda = 1'b0;

  int checks = 0;
  int errors = 0;

  i2c_bit_ctrl_if bus_if ();

  // Open-drain wired-AND of the DUT and an external agent.
  assign scl_in = ~scl_oe & ext_scl;
  assign sda_in = ~sda_oe & ext_sda;

  i2c_bit_ctrl #(.SYNC_STAGES(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .clk_tick (clk_tick),
    .tick_en  (tick_en),
    .cmd_if   (bus_if),
    .scl_in   (scl_in),
    .sda_in   (sda_in),
    .scl_oe   (scl_oe),
    .sda_oe   (sda_oe)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_lines(input string tag);
    check({tag, "_scl"}, scl_oe, exp_scl);
    check({tag, "_sda"}, sda_oe, exp_sda);
  endtask

  // Line drive for phase k of a command: {scl_oe, sda_oe}.
  function automatic logic [1:0] phase_lines(input logic [1:0] c, input int k,
                                             input logic wb, input logic prev_sda);
    logic [1:0] r;
    case (c)
      CmdStart: r = {1'b0, k >= 5};
      CmdStop:  r = {k <= 2, k <= 6};
      CmdWrite: r = {k <= 4, (k >= 2) ? ~wb : prev_sda};
      default:  r = {k <= 4, 1'b0};
    endcase
    return r;
  endfunction

  task automatic run_cmd(input logic [1:0] c, input logic wb, input logic ext_d,
                         input int stretch_ph, input int reset_ph, output logic aborted);
    logic [1:0] ln;
    logic       exp_rd;
    logic       bus_sda;
    logic       lost;
    int         gap;
    lost    = 1'b0;
    aborted = 1'b0;
    exp_rd  = 1'b0;

    // Ticks while idle must be ignored.
    repeat ($urandom_range(0, 2)) begin
      clk_tick = 1'b1;
      step();
      clk_tick = 1'b0;
      check("idle_busy", bus_if.busy, 1'b0);
      check_lines("idle_hold");
    end

    bus_if.cmd       = c;
    bus_if.wr_bit    = wb;
    bus_if.cmd_valid = 1'b1;
    ext_sda          = ext_d;
    check("ready_idle", bus_if.cmd_ready, 1'b1);
    step();
    bus_if.cmd_valid = 1'b0;
    check("busy_accept", bus_if.busy, 1'b1);
    check("ready_accept", bus_if.cmd_ready, 1'b0);
    check("tick_en_accept", tick_en, 1'b1);

    for (int k = 0; k < 10; k++) begin
      ln      = phase_lines(c, k, wb, exp_sda);
      exp_scl = ln[1];
      exp_sda = ln[0];
      check_lines("phase_entry");

      if (k == reset_ph) begin
        #3 reset = 1'b0;
        #1;
        check("rst_scl_oe", scl_oe, 1'b0);
        check("rst_sda_oe", sda_oe, 1'b0);
        check("rst_busy", bus_if.busy, 1'b0);
        check("rst_tick_en", tick_en, 1'b0);
        check("rst_ready", bus_if.cmd_ready, 1'b1);
        repeat (2) step();
        reset = 1'b1;
        step();
        exp_scl = 1'b0;
        exp_sda = 1'b0;
        ext_sda = 1'b1;
        aborted = 1'b1;
        return;
      end

      if (k == stretch_ph) begin
        ext_scl = 1'b0;
        for (int i = 0; i < 50; i++) begin
          clk_tick = (i % 10 == 5);
          bus_if.cmd_valid = 1'($urandom_range(0, 1));
          step();
          check_lines("stretch_hold");
          check("stretch_done", bus_if.done, 1'b0);
          check("stretch_busy", bus_if.busy, 1'b1);
        end
        clk_tick         = 1'b0;
        bus_if.cmd_valid = 1'b0;
        ext_scl          = 1'b1;
      end

      gap = $urandom_range(6, 12);
      for (int i = 0; i < gap; i++) begin
        bus_if.cmd_valid = 1'($urandom_range(0, 1));
        bus_if.cmd       = 2'($urandom_range(0, 3));
        bus_if.wr_bit    = 1'($urandom_range(0, 1));
        step();
        check_lines("phase_hold");
        check("phase_done", bus_if.done, 1'b0);
        check("phase_arb", bus_if.arb_lost, 1'b0);
        check("phase_busy", bus_if.busy, 1'b1);
      end
      bus_if.cmd_valid = 1'b0;

      // Reference: bus value seen at this tick and the rules applied to it.
      bus_sda = ~exp_sda & ext_sda;
      if (c == CmdStart && k <= 4 && !bus_sda) lost = 1'b1;
      if (c == CmdStop && k >= 8 && !bus_sda) lost = 1'b1;
      if ((c == CmdWrite || c == CmdRead) && k == 6) begin
        exp_rd = bus_sda;
        if (c == CmdWrite && wb && !bus_sda) lost = 1'b1;
      end

      clk_tick = 1'b1;
      step();
      clk_tick = 1'b0;

      if (lost) begin
        exp_scl = 1'b0;
        exp_sda = 1'b0;
        check("arb_pulse", bus_if.arb_lost, 1'b1);
        check("arb_no_done", bus_if.done, 1'b0);
        check("arb_ready", bus_if.cmd_ready, 1'b1);
        check("arb_busy", bus_if.busy, 1'b0);
        check_lines("arb_release");
        aborted = 1'b1;
        break;
      end
    end

    if (!lost) begin
      check("done_pulse", bus_if.done, 1'b1);
      check("done_arb", bus_if.arb_lost, 1'b0);
      check("done_ready", bus_if.cmd_ready, 1'b1);
      check("done_busy", bus_if.busy, 1'b0);
      check("done_tick_en", tick_en, 1'b0);
      if (c == CmdWrite || c == CmdRead) check("rd_bit", bus_if.rd_bit, exp_rd);
    end
    step();
    check("done_one_cycle", bus_if.done, 1'b0);
    check("arb_one_cycle", bus_if.arb_lost, 1'b0);
    check_lines("after_hold");
    ext_sda = 1'b1;
  endtask

  initial begin
    logic [1:0] c;
    logic       ab;
    logic       wb;
    logic       ext;
    logic       bus_idle;
    int         stretch;
    int         lo;

    bus_if.cmd_valid = 1'b0;
    bus_if.cmd       = 2'b00;
    bus_if.wr_bit    = 1'b0;
    #2 reset = 1'b0;
    repeat (3) step();
    check("reset_scl_oe", scl_oe, 1'b0);
    check("reset_sda_oe", sda_oe, 1'b0);
    check("reset_ready", bus_if.cmd_ready, 1'b1);
    check("reset_tick_en", tick_en, 1'b0);
    check("reset_busy", bus_if.busy, 1'b0);
    check("reset_done", bus_if.done, 1'b0);
    check("reset_arb", bus_if.arb_lost, 1'b0);
    check("reset_rd_bit", bus_if.rd_bit, 1'b0);
    reset = 1'b1;
    step();

    // Directed sequence following the plan.
    run_cmd(CmdStart, 1'b0, 1'b1, -1, -1, ab);
    run_cmd(CmdStop,  1'b0, 1'b1, -1, -1, ab);
    run_cmd(CmdStart, 1'b0, 1'b1, -1, -1, ab);
    run_cmd(CmdWrite, 1'b0, 1'b1, -1, -1, ab);
    run_cmd(CmdWrite, 1'b1, 1'b1, -1, -1, ab);
    run_cmd(CmdRead,  1'b0, 1'b0, -1, -1, ab);
    run_cmd(CmdRead,  1'b0, 1'b1, -1, -1, ab);
    run_cmd(CmdWrite, 1'b1, 1'b1,  5, -1, ab);
    run_cmd(CmdStop,  1'b0, 1'b1, -1, -1, ab);
    run_cmd(CmdStart, 1'b0, 1'b1, -1, -1, ab);
    run_cmd(CmdWrite, 1'b1, 1'b0, -1, -1, ab);
    check("arb_write_reported", ab, 1'b1);
    run_cmd(CmdStart, 1'b0, 1'b1, -1, -1, ab);
    run_cmd(CmdStop,  1'b0, 1'b1, -1,  3, ab);
    run_cmd(CmdStart, 1'b0, 1'b1, -1, -1, ab);
    run_cmd(CmdStop,  1'b0, 1'b1, -1, -1, ab);

    // Randomized legal bus sequences.
    bus_idle = 1'b1;
    for (int n = 0; n < 40; n++) begin
      if (bus_idle) begin
        c = CmdStart;
      end else begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3: c = CmdWrite;
          4, 5, 6:    c = CmdRead;
          7, 8:       c = CmdStop;
          default:    c = exp_sda ? CmdStop : CmdStart;
        endcase
      end
      wb  = 1'($urandom_range(0, 1));
      ext = ($urandom_range(0, 7) != 0);
      if (c == CmdRead) ext = 1'($urandom_range(0, 1));
      lo = (c == CmdStart) ? 0 : (c == CmdStop) ? 3 : 5;
      stretch = ($urandom_range(0, 3) == 0) ? int'($urandom_range(lo, 9)) : -1;
      run_cmd(c, wb, ext, stretch, -1, ab);
      bus_idle = ab || (c == CmdStop);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
